// File: rtl/spi_cfg_controller_if.sv
// Requester-side bundle of the SPI configuration controller: two write
// requesters, abort, and completion status.
interface spi_cfg_controller_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;
  logic       abort;
  logic       busy;
  logic       done;
  logic       done_id;

  modport master (
    output req_valid, req0_addr, req0_data, req1_addr, req1_data, abort,
    input  req_ready, busy, done, done_id
  );

  modport slave (
    input  req_valid, req0_addr, req0_data, req1_addr, req1_data, abort,
    output req_ready, busy, done, done_id
  );
endinterface

// File: rtl/spi_cfg_controller.sv
// Mode-0 SPI write controller for the peripheral register file: two requesters
// arbitrated round-robin, one 16-bit {1, addr[6:0], data[7:0]} frame per accept.
//
// state | meaning
// IDLE  | waiting for a request; req_ready offered here only
// LEAD  | ncs low, sclk low, first bit on copi (CS_SETUP cycles)
// LOW   | sclk low half-period, current bit on copi (CLK_DIV cycles)
// HIGH  | sclk high half-period, peripheral samples (CLK_DIV cycles)
// TRAIL | ncs held low after the last sclk fall (CLK_DIV cycles)
// GAP   | ncs high before the next accept (CS_IDLE cycles)
module spi_cfg_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_cfg_controller_if.slave   bus,
  output logic                  spi_ncs,
  output logic                  spi_copi,
  output logic                  spi_sclk
);

  typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, TRAIL, GAP} state_t;

  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] IDLE_LD  = 8'(CS_IDLE - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [15:0] shift_q;
  logic [1:0]  ready_q;
  logic        last_grant_q;
  logic        ncs_q, copi_q, sclk_q, busy_q, done_q, done_id_q;

  logic        grant_d;
  logic [1:0]  offer_d;
  logic        take_d;
  logic [15:0] frame_d;
  logic        abort_d;

  always_comb begin
    grant_d = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
    offer_d = 2'b00;
    if (bus.req_valid != 2'b00) offer_d = grant_d ? 2'b10 : 2'b01;
    take_d  = (bus.req_valid & ready_q) != 2'b00;
    frame_d = ready_q[1] ? {1'b1, bus.req1_addr, bus.req1_data}
                         : {1'b1, bus.req0_addr, bus.req0_data};
    abort_d = bus.abort && (state_q != IDLE) && (state_q != GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      bit_q        <= 4'd0;
      shift_q      <= 16'd0;
      ready_q      <= 2'b00;
      last_grant_q <= 1'b1;
      ncs_q        <= 1'b1;
      copi_q       <= 1'b0;
      sclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      ready_q <= 2'b00;
      done_q  <= 1'b0;
      if (abort_d) begin
        state_q <= GAP;
        cnt_q   <= IDLE_LD;
        ncs_q   <= 1'b1;
        sclk_q  <= 1'b0;
        copi_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // ready is offered one cycle ahead so the accept itself is registered
            if (take_d) begin
              state_q      <= LEAD;
              cnt_q        <= SETUP_LD;
              bit_q        <= 4'd0;
              shift_q      <= frame_d;
              last_grant_q <= ready_q[1];
              ncs_q        <= 1'b0;
              sclk_q       <= 1'b0;
              copi_q       <= 1'b1;
              busy_q       <= 1'b1;
            end else if (ready_q == 2'b00) begin
              ready_q <= offer_d;
            end
          end
          LEAD: begin
            if (cnt_q == 8'd0) begin
              state_q <= LOW;
              cnt_q   <= DIV_LD;
            end else cnt_q <= cnt_q - 8'd1;
          end
          LOW: begin
            if (cnt_q == 8'd0) begin
              state_q <= HIGH;
              cnt_q   <= DIV_LD;
              sclk_q  <= 1'b1;
            end else cnt_q <= cnt_q - 8'd1;
          end
          HIGH: begin
            if (cnt_q == 8'd0) begin
              cnt_q   <= DIV_LD;
              sclk_q  <= 1'b0;
              shift_q <= {shift_q[14:0], 1'b0};
              if (bit_q == 4'd15) begin
                state_q <= TRAIL;
              end else begin
                state_q <= LOW;
                bit_q   <= bit_q + 4'd1;
                copi_q  <= shift_q[14];
              end
            end else cnt_q <= cnt_q - 8'd1;
          end
          TRAIL: begin
            if (cnt_q == 8'd0) begin
              state_q   <= GAP;
              cnt_q     <= IDLE_LD;
              ncs_q     <= 1'b1;
              copi_q    <= 1'b0;
              done_q    <= 1'b1;
              done_id_q <= last_grant_q;
            end else cnt_q <= cnt_q - 8'd1;
          end
          GAP: begin
            if (cnt_q == 8'd0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= offer_d;
            end else cnt_q <= cnt_q - 8'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign spi_ncs       = ncs_q;
  assign spi_copi      = copi_q;
  assign spi_sclk      = sclk_q;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Bench for spi_cfg_controller: default-parameter instance plus a CLK_DIV=2
// instance, an SPI frame monitor acting as the peripheral register file.
module tb_spi_cfg_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  spi_cfg_controller_if ifa();
  spi_cfg_controller_if ifb();
  logic ncs_a, copi_a, sclk_a, ncs_b, copi_b, sclk_b;

  spi_cfg_controller u_a (.clk(clk), .rst_n(rst_n), .bus(ifa),
                          .spi_ncs(ncs_a), .spi_copi(copi_a), .spi_sclk(sclk_a));
  spi_cfg_controller #(.CLK_DIV(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb),
                          .spi_ncs(ncs_b), .spi_copi(copi_b), .spi_sclk(sclk_b));

  logic       ncs_w[2], copi_w[2], sclk_w[2], busy_w[2], done_w[2], did_w[2];
  logic [1:0] rdy_w[2];
  assign ncs_w[0] = ncs_a;   assign ncs_w[1] = ncs_b;
  assign copi_w[0] = copi_a; assign copi_w[1] = copi_b;
  assign sclk_w[0] = sclk_a; assign sclk_w[1] = sclk_b;
  assign busy_w[0] = ifa.busy; assign busy_w[1] = ifb.busy;
  assign done_w[0] = ifa.done; assign done_w[1] = ifb.done;
  assign did_w[0] = ifa.done_id; assign did_w[1] = ifb.done_id;
  assign rdy_w[0] = ifa.req_ready; assign rdy_w[1] = ifb.req_ready;

  // peripheral model: frames complete only when ncs rises after 16 sclk rises
  logic [15:0] sh_m[2];
  int          nb_m[2], low_m[2], len_m[2], hi_run[2], lo_run[2];
  int          hi_min[2] = '{1000, 1000};
  int          lo_min[2] = '{1000, 1000};
  int          hi_max[2], lo_max[2];
  logic        ncs_p[2] = '{1'b1, 1'b1};
  logic        sclk_p[2] = '{1'b0, 1'b0};
  logic [15:0] frq0[$], frq1[$];
  logic [7:0]  per_reg[2][5] = '{default: 8'h00};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ncs_w[i]) begin
        low_m[i]++;
        if (sclk_w[i] && !sclk_p[i]) begin
          if (nb_m[i] > 0) begin
            if (lo_run[i] < lo_min[i]) lo_min[i] = lo_run[i];
            if (lo_run[i] > lo_max[i]) lo_max[i] = lo_run[i];
          end
          sh_m[i] = {sh_m[i][14:0], copi_w[i]};
          nb_m[i]++;
          hi_run[i] = 1;
        end else if (sclk_w[i]) begin
          hi_run[i]++;
        end else if (sclk_p[i]) begin
          if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
          if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
          lo_run[i] = 1;
        end else begin
          lo_run[i]++;
        end
      end else if (!ncs_p[i]) begin
        len_m[i] = low_m[i];
        if (nb_m[i] == 16) begin
          if (i == 0) frq0.push_back(sh_m[i]);
          else        frq1.push_back(sh_m[i]);
          if (sh_m[i][15] && sh_m[i][14:8] < 7'd5) per_reg[i][sh_m[i][10:8]] = sh_m[i][7:0];
        end
        low_m[i] = 0;
        nb_m[i]  = 0;
        lo_run[i] = 0;
      end
      ncs_p[i]  = ncs_w[i];
      sclk_p[i] = sclk_w[i];
    end
  end

  int         nvec = 0;
  int         nmis = 0;
  logic [7:0] exp_reg[2][5] = '{default: 8'h00};
  logic       m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int u, input logic [1:0] vld, input logic [6:0] a0,
                       input logic [7:0] d0, input logic [6:0] a1, input logic [7:0] d1);
    if (u == 0) begin
      ifa.req_valid = vld; ifa.req0_addr = a0; ifa.req0_data = d0;
      ifa.req1_addr = a1;  ifa.req1_data = d1;
    end else begin
      ifb.req_valid = vld; ifb.req0_addr = a0; ifb.req0_data = d0;
      ifb.req1_addr = a1;  ifb.req1_data = d1;
    end
  endtask

  task automatic set_valid(input int u, input logic [1:0] vld);
    if (u == 0) ifa.req_valid = vld;
    else        ifb.req_valid = vld;
  endtask

  task automatic get_frame(input int u, output logic [15:0] f, output logic ok);
    ok = 1'b0;
    f  = 16'h0;
    if (u == 0 && frq0.size() > 0) begin f = frq0.pop_front(); ok = 1'b1; end
    if (u == 1 && frq1.size() > 0) begin f = frq1.pop_front(); ok = 1'b1; end
  endtask

  task automatic record(input int u, input logic [6:0] addr, input logic [7:0] data);
    if (addr < 7'd5) exp_reg[u][addr[2:0]] = data;
  endtask

  // single-requester frame with full timing checks; expected delays from the
  // parameters: done = CS_SETUP + 33*CLK_DIV + 1 cycles after the accept
  task automatic do_frame(input int u, input logic sel, input logic [6:0] addr,
                          input logic [7:0] data, input logic [15:0] exp_f, input logic exp_id);
    int dly;
    int n;
    logic got;
    logic [1:0] oh;
    logic [15:0] f;
    dly = (u == 0) ? 4 + 33 * 4 + 1 : 4 + 33 * 2 + 1;
    oh  = sel ? 2'b10 : 2'b01;
    if (sel) drive(u, oh, ~addr, ~data, addr, data);
    else     drive(u, oh, addr, data, ~addr, ~data);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (rdy_w[u] != 2'b00) got = 1'b1;
    end
    chk("ready_seen", {31'd0, got}, 32'd1);
    if (!got) begin set_valid(u, 2'b00); return; end
    chk("ready_onehot", {30'd0, rdy_w[u]}, {30'd0, oh});
    chk("busy_at_accept", {31'd0, busy_w[u]}, 32'd0);
    @(negedge clk);
    set_valid(u, 2'b00);
    n = 1;
    chk("ncs_low_after_accept", {31'd0, ncs_w[u]}, 32'd0);
    chk("busy_after_accept", {31'd0, busy_w[u]}, 32'd1);
    while (!done_w[u] && n < dly + 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_delay", n, dly);
    chk("done_id", {31'd0, did_w[u]}, {31'd0, exp_id});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) chk("busy_last_gap", {31'd0, busy_w[u]}, 32'd1);
      if (k == 4) chk("busy_cleared", {31'd0, busy_w[u]}, 32'd0);
    end
    chk("ncs_low_len", len_m[u], dly - 1);
    get_frame(u, f, got);
    chk("frame_present", {31'd0, got}, 32'd1);
    chk("frame_bits", {16'd0, f}, {16'd0, exp_f});
    record(u, addr, data);
    if (u == 0) m_last = sel;
    if (addr < 7'd5) chk("periph_reg", {24'd0, per_reg[u][addr[2:0]]}, {24'd0, exp_reg[u][addr[2:0]]});
  endtask

  // reference: requesters hold until ready; with both pending the one not
  // served last wins, the other follows
  task automatic serve(input logic [1:0] pat, input logic [6:0] a0, input logic [7:0] d0,
                       input logic [6:0] a1, input logic [7:0] d1);
    int need, nacc, ndone, cyc;
    int acc[2], dn[2];
    logic ord[2];
    logic [1:0] vld, pend;
    logic [15:0] f, ef;
    logic ok;
    need   = int'(pat[0]) + int'(pat[1]);
    ord[0] = (pat == 2'b11) ? !m_last : pat[1];
    ord[1] = !ord[0];
    acc = '{-1, -1};
    dn  = '{-1, -1};
    nacc = 0; ndone = 0; cyc = 0;
    vld = pat; pend = 2'b00;
    drive(0, pat, a0, d0, a1, d1);
    while (ndone < need && cyc < need * 200) begin
      @(negedge clk);
      cyc++;
      if (pend != 2'b00) begin
        vld = vld & ~pend;
        pend = 2'b00;
        ifa.req_valid = vld;
      end
      if (rdy_w[0] != 2'b00) begin
        if (nacc < 2) acc[nacc] = int'(rdy_w[0][1]);
        nacc++;
        pend = rdy_w[0];
      end
      if (done_w[0]) begin
        if (ndone < 2) dn[ndone] = int'(did_w[0]);
        ndone++;
      end
    end
    chk("serve_done_count", ndone, need);
    chk("serve_accept_count", nacc, need);
    @(negedge clk);
    for (int k = 0; k < need; k++) begin
      chk("grant_order", acc[k], int'(ord[k]));
      chk("done_id_order", dn[k], int'(ord[k]));
      ef = ord[k] ? {1'b1, a1, d1} : {1'b1, a0, d0};
      get_frame(0, f, ok);
      chk("serve_frame", {15'd0, ok, f}, {15'd0, 1'b1, ef});
      if (ord[k]) record(0, a1, d1);
      else        record(0, a0, d0);
      m_last = ord[k];
    end
  endtask

  typedef struct {
    int          u;
    logic        sel;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
    logic        id;
  } vec_t;
  vec_t tbl[5];

  initial begin : main
    int n, nr, nd, rc[3], dc[3];
    logic got, sawdone, drop;
    logic [15:0] f;
    logic [1:0] pat;

    tbl[0] = '{0, 1'b0, 7'd0, 8'hA5, 16'h80A5, 1'b0};
    tbl[1] = '{0, 1'b1, 7'd1, 8'h3C, 16'h813C, 1'b1};
    tbl[2] = '{0, 1'b0, 7'd3, 8'h00, 16'h8300, 1'b0};
    tbl[3] = '{0, 1'b1, 7'd4, 8'hFF, 16'h84FF, 1'b1};
    tbl[4] = '{1, 1'b0, 7'd2, 8'h5A, 16'h825A, 1'b0};

    rst_n = 1'b0;
    ifa.abort = 1'b0; ifb.abort = 1'b0;
    drive(0, 2'b11, 7'd4, 8'h80, 7'd2, 8'hFF);
    drive(1, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00);
    m_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ncs", {31'd0, ncs_a}, 32'd1);
    chk("rst_sclk", {31'd0, sclk_a}, 32'd0);
    chk("rst_copi", {31'd0, copi_a}, 32'd0);
    chk("rst_ready", {30'd0, ifa.req_ready}, 32'd0);
    chk("rst_busy", {31'd0, ifa.busy}, 32'd0);
    chk("rst_done", {31'd0, ifa.done}, 32'd0);
    chk("rst_done_id", {31'd0, ifa.done_id}, 32'd0);
    rst_n = 1'b1;

    serve(2'b11, 7'd4, 8'h80, 7'd2, 8'hFF);
    chk("pwm_duty", {24'd0, per_reg[0][4]}, 32'h80);
    chk("pwm_en", {24'd0, per_reg[0][2]}, 32'hFF);

    for (int i = 0; i < 5; i++)
      do_frame(tbl[i].u, tbl[i].sel, tbl[i].addr, tbl[i].data, tbl[i].frame, tbl[i].id);
    chk("sclk_hi_min_div2", hi_min[1], 2);
    chk("sclk_hi_max_div2", hi_max[1], 2);
    chk("sclk_lo_min_div2", lo_min[1], 2);
    chk("sclk_lo_max_div2", lo_max[1], 2);

    // req0 held across three frames
    drive(0, 2'b01, 7'd1, 8'h77, 7'd0, 8'h00);
    nr = 0; nd = 0; n = 0; drop = 1'b0;
    rc = '{0, 0, 0}; dc = '{0, 0, 0};
    while (nd < 3 && n < 600) begin
      @(negedge clk);
      n++;
      if (drop) begin set_valid(0, 2'b00); drop = 1'b0; end
      if (rdy_w[0] != 2'b00) begin
        if (nr < 3) rc[nr] = n;
        nr++;
        if (nr == 3) drop = 1'b1;
      end
      if (done_w[0]) begin
        if (nd < 3) dc[nd] = n;
        nd++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (rdy_w[0] != 2'b00) nr++;
    end
    chk("held_done_count", nd, 3);
    chk("held_accept_count", nr, 3);
    chk("held_accept_spacing1", rc[1] - rc[0], 141);
    chk("held_accept_spacing2", rc[2] - rc[1], 141);
    chk("held_done_latency", dc[0] - rc[0], 137);
    chk("held_ncs_high_before_accept", rc[1] - dc[0], 4);
    for (int k = 0; k < 3; k++) begin
      get_frame(0, f, got);
      chk("held_frame", {15'd0, got, f}, {15'd0, 1'b1, 16'h8177});
    end
    record(0, 7'd1, 8'h77);
    m_last = 1'b0;

    // abort mid-frame
    drive(0, 2'b10, 7'd0, 8'h00, 7'd3, 8'h55);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (rdy_w[0] != 2'b00) got = 1'b1;
    end
    chk("abort_ready_seen", {31'd0, got}, 32'd1);
    sawdone = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) set_valid(0, 2'b00);
      if (n == 50) ifa.abort = 1'b1;
      if (n == 51) begin
        chk("abort_ncs", {31'd0, ncs_a}, 32'd1);
        chk("abort_sclk", {31'd0, sclk_a}, 32'd0);
        ifa.abort = 1'b0;
      end
      if (n == 54) chk("abort_busy_gap", {31'd0, ifa.busy}, 32'd1);
      if (n == 55) chk("abort_busy_clear", {31'd0, ifa.busy}, 32'd0);
      if (done_w[0]) sawdone = 1'b1;
    end
    chk("abort_no_done", {31'd0, sawdone}, 32'd0);
    chk("abort_reg_kept", {24'd0, per_reg[0][3]}, {24'd0, exp_reg[0][3]});
    m_last = 1'b1;
    do_frame(0, 1'b0, 7'd2, 8'h9C, 16'h829C, 1'b0);

    for (int it = 0; it < 20; it++) begin
      pat = 2'($urandom_range(1, 3));
      serve(pat, 7'($urandom_range(0, 4)), 8'($urandom), 7'($urandom_range(0, 4)), 8'($urandom));
    end

    // reset mid-frame
    drive(0, 2'b01, 7'd2, 8'h11, 7'd0, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (rdy_w[0] != 2'b00) got = 1'b1;
    end
    chk("rstmid_ready_seen", {31'd0, got}, 32'd1);
    for (n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (n == 1) set_valid(0, 2'b00);
    end
    rst_n = 1'b0;
    #1;
    chk("rstmid_ncs", {31'd0, ncs_a}, 32'd1);
    chk("rstmid_sclk", {31'd0, sclk_a}, 32'd0);
    chk("rstmid_copi", {31'd0, copi_a}, 32'd0);
    chk("rstmid_busy", {31'd0, ifa.busy}, 32'd0);
    drive(0, 2'b11, 7'd1, 8'h22, 7'd3, 8'h33);
    @(negedge clk);
    chk("rstmid_ready", {30'd0, ifa.req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    serve(2'b11, 7'd1, 8'h22, 7'd3, 8'h33);

    for (int a = 0; a < 5; a++)
      chk("final_reg", {24'd0, per_reg[0][a]}, {24'd0, exp_reg[0][a]});
    chk("final_reg_b", {24'd0, per_reg[1][2]}, {24'd0, exp_reg[1][2]});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
